prog_minterm_lut: RTL

- Parametrised, pipelined, run-time-programmable multi-output sum-of-minterms evaluator.
- A one-hot decode of an N_IN-bit input vector selects one minterm. Each of N_OUT outputs is the OR of its enabled minterms, taken from a truth table held in registers.
- The table is loaded serially through a handshake into a shadow copy, then committed atomically. Evaluation keeps running on the active copy during a load.
- Used wherever the team previously hard-wired decoder-plus-OR function blocks.

---
 rtl/prog_minterm_lut.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/prog_minterm_lut.sv
// prog_minterm_lut: pipelined sum-of-minterms evaluator with a serially loaded,
// atomically committed truth table. Evaluation always reads the active table
// while a new one is shifted into the shadow copy.
module prog_minterm_lut #(
   parameter int N_IN = 3,
   parameter int N_OUT = 2,
   parameter logic [N_OUT*(2**N_IN)-1:0] RESET_TABLE = 16'hC028
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [N_IN-1:0] in_vec,
   output logic            out_valid,
   output logic [N_OUT-1:0] f,
   input  logic            cfg_start,
   input  logic            cfg_valid,
   input  logic            cfg_bit,
   output logic            cfg_ready,
   output logic            cfg_done,
   output logic            cfg_err
);

   localparam int MINTERMS   = 2**N_IN;
   localparam int TABLE_BITS = N_OUT*MINTERMS;
   localparam int CNT_W      = $clog2(TABLE_BITS+1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TABLE_BITS-1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [MINTERMS-1:0] ONEHOT_LSB = MINTERMS'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } cfg_state_t;

   cfg_state_t state;
   cfg_state_t state_next;

   logic [CNT_W-1:0]      count;
   logic [TABLE_BITS-1:0] shadow;
   logic [TABLE_BITS-1:0] active;

   logic accept;
   logic abort;
   logic clear;
   logic commit;

   logic [MINTERMS-1:0] onehot_next;
   logic [MINTERMS-1:0] onehot1;
   logic                v1;
   logic [N_OUT-1:0]    f_next;

   // Config state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Config next-state and strobes; cfg_start beats a same-cycle cfg_valid in SHIFT
   always_comb begin
      state_next = state;
      cfg_ready  = 1'b0;
      cfg_done   = 1'b0;
      accept     = 1'b0;
      abort      = 1'b0;
      clear      = 1'b0;
      commit     = 1'b0;
      unique case (state)
         IDLE: begin
            if (cfg_start) begin
               clear      = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            cfg_ready = 1'b1;
            if (cfg_start) begin
               abort = 1'b1;
               clear = 1'b1;
            end else if (cfg_valid) begin
               accept = 1'b1;
               if (count == LAST_IDX) begin
                  state_next = COMMIT;
               end
            end
         end
         COMMIT: begin
            cfg_done   = 1'b1;
            commit     = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Bit counter for the serial load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (accept) begin
         count <= count + CNT_ONE;
      end
   end

   // Shadow table: accepted bits land at the current counter position
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= RESET_TABLE;
      end else if (accept) begin
         for (int i = 0; i < TABLE_BITS; i++) begin
            if (count == CNT_W'(i)) begin
               shadow[i] <= cfg_bit;
            end
         end
      end
   end

   // Active table: whole shadow copied in one edge so no output sees a mix
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= RESET_TABLE;
      end else if (commit) begin
         active <= shadow;
      end
   end

   // Abort pulse appears the cycle after the restarting cfg_start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= abort;
      end
   end

   // Minterm decode of the incoming select vector
   always_comb begin
      onehot_next = ONEHOT_LSB << in_vec;
   end

   // Stage 1: capture decoded minterm
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1      <= 1'b0;
         onehot1 <= '0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            onehot1 <= onehot_next;
         end
      end
   end

   // Each output is the OR of its enabled minterms in the active table
   always_comb begin
      f_next = '0;
      for (int o = 0; o < N_OUT; o++) begin
         f_next[o] = |(onehot1 & active[o*MINTERMS +: MINTERMS]);
      end
   end

   // Stage 2: register results; f holds through bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         f         <= '0;
      end else begin
         out_valid <= v1;
         if (v1) begin
            f <= f_next;
         end
      end
   end

endmodule
